// File: rtl/btn_conditioner.sv
// Button conditioner: two-flop synchroniser plus a debounce/hold FSM per channel,
// producing a clean level and one-cycle press, release and long-press pulses.
module btn_conditioner #(
    parameter int N_BTN       = 5,
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int DEB_CYCLES  = 500000,
    parameter int CNT_W       = 20,
    parameter int LONG_CYCLES = 50000000,
    parameter int LONG_W      = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DCNT_ONE  = CNT_W'(1);
    localparam logic [LONG_W-1:0] HCNT_ONE  = LONG_W'(1);

    logic [N_BTN-1:0]  raw_in;
    logic [N_BTN-1:0]  s1_q, s1_d, s2_q, s2_d;
    state_t            state_q [N_BTN];
    state_t            state_d [N_BTN];
    logic [CNT_W-1:0]  dcnt_q  [N_BTN];
    logic [CNT_W-1:0]  dcnt_d  [N_BTN];
    logic [LONG_W-1:0] hcnt_q  [N_BTN];
    logic [LONG_W-1:0] hcnt_d  [N_BTN];
    logic [N_BTN-1:0]  long_done_q, long_done_d;
    logic [N_BTN-1:0]  level_q, level_d;
    logic [N_BTN-1:0]  press_q, press_d;
    logic [N_BTN-1:0]  release_q, release_d;
    logic [N_BTN-1:0]  long_q, long_d;

    // Normalise polarity before the synchroniser so everything downstream sees 1 = pressed.
    assign raw_in = ACTIVE_HIGH ? btn_raw : ~btn_raw;

    always_comb begin
        s1_d        = raw_in;
        s2_d        = s1_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            case (state_q[i])
                IDLE: begin
                    level_d[i] = 1'b0;
                    if (s2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        dcnt_d[i]  = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i]     = PRESSED;
                        level_d[i]     = 1'b1;
                        press_d[i]     = 1'b1;
                        hcnt_d[i]      = '0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
                    end
                end
                PRESSED: begin
                    level_d[i] = 1'b1;
                    if (!s2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        dcnt_d[i]  = '0;
                    end else if (!long_done_q[i] && hcnt_q[i] == LONG_LAST) begin
                        long_d[i]      = 1'b1;
                        long_done_d[i] = 1'b1;
                    end
                    // Hold time accrues for every cycle spent in PRESSED, so a release
                    // bounce costs exactly its RELEASE_WAIT cycles; saturates at terminal.
                    if (!long_done_q[i] && hcnt_q[i] != LONG_LAST) begin
                        hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    level_d[i] = 1'b1;
                    if (s2_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i]   = IDLE;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            long_done_q <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CYCLES=4, LONG_CYCLES=16: one
// active-high instance and one active-low instance sharing clock and reset.
module tb_btn_conditioner;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_a, raw_b;
    logic [N-1:0] lvl_a, prs_a, rel_a, lng_a;
    logic [N-1:0] lvl_b, prs_b, rel_b, lng_b;
    int           checks = 0;
    int           failures = 0;

    btn_conditioner #(
        .N_BTN(N), .ACTIVE_HIGH(1'b1), .DEB_CYCLES(4), .CNT_W(2),
        .LONG_CYCLES(16), .LONG_W(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_a),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
    );

    btn_conditioner #(
        .N_BTN(N), .ACTIVE_HIGH(1'b0), .DEB_CYCLES(4), .CNT_W(2),
        .LONG_CYCLES(16), .LONG_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_b),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw_a = '0;
        raw_b = '1;
        tick();
        tick();
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a} !== 20'h0) begin
            failures++;
            $display("FAIL reset_a got=%h want=0", {lvl_a, prs_a, rel_a, lng_a});
        end
        checks++;
        if ({lvl_b, prs_b, rel_b, lng_b} !== 20'h0) begin
            failures++;
            $display("FAIL reset_b got=%h want=0", {lvl_b, prs_b, rel_b, lng_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a, lvl_b, prs_b, rel_b, lng_b} !== 40'h0) begin
                failures++;
                $display("FAIL idle_after_reset e=%0d a=%h b=%h want=0", e,
                         {lvl_a, prs_a, rel_a, lng_a}, {lvl_b, prs_b, rel_b, lng_b});
            end
        end
    endtask

    task automatic test_clean_press();
        raw_a[1] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (prs_a !== ((e == 7) ? 5'b00010 : 5'b00000)) begin
                failures++;
                $display("FAIL press e=%0d got=%b want=%b", e, prs_a, (e == 7) ? 5'b00010 : 5'b00000);
            end
            checks++;
            if (lvl_a !== ((e >= 7) ? 5'b00010 : 5'b00000)) begin
                failures++;
                $display("FAIL press_level e=%0d got=%b", e, lvl_a);
            end
            checks++;
            if (lng_a !== ((e == 23) ? 5'b00010 : 5'b00000)) begin
                failures++;
                $display("FAIL long e=%0d got=%b want=%b", e, lng_a, (e == 23) ? 5'b00010 : 5'b00000);
            end
            checks++;
            if (rel_a !== 5'b00000) begin
                failures++;
                $display("FAIL press_no_release e=%0d got=%b want=00000", e, rel_a);
            end
        end
    endtask

    task automatic test_clean_release();
        raw_a[1] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (rel_a !== ((e == 7) ? 5'b00010 : 5'b00000)) begin
                failures++;
                $display("FAIL release e=%0d got=%b", e, rel_a);
            end
            checks++;
            if (lvl_a !== ((e < 7) ? 5'b00010 : 5'b00000)) begin
                failures++;
                $display("FAIL release_level e=%0d got=%b", e, lvl_a);
            end
            checks++;
            if ({prs_a, lng_a} !== 10'h0) begin
                failures++;
                $display("FAIL release_no_press_long e=%0d got=%b_%b want=0", e, prs_a, lng_a);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b00110111;  // applied LSB first: 1,1,1,0,1,1,0,0
        for (int e = 0; e < 18; e++) begin
            raw_a[0] = (e < 8) ? pat[e] : 1'b0;
            tick();
            checks++;
            if ({prs_a, lvl_a, rel_a} !== 15'h0) begin
                failures++;
                $display("FAIL bounce e=%0d prs=%b lvl=%b rel=%b want=0", e, prs_a, lvl_a, rel_a);
            end
        end
    endtask

    task automatic test_glitch_while_pressed();
        raw_a[3] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            if (e == 11) raw_a[3] = 1'b0;
            if (e == 13) raw_a[3] = 1'b1;
            tick();
            checks++;
            if (prs_a !== ((e == 7) ? 5'b01000 : 5'b00000)) begin
                failures++;
                $display("FAIL glitch_press e=%0d got=%b", e, prs_a);
            end
            checks++;
            if (lvl_a !== ((e >= 7) ? 5'b01000 : 5'b00000)) begin
                failures++;
                $display("FAIL glitch_level e=%0d got=%b", e, lvl_a);
            end
            checks++;
            if (rel_a !== 5'b00000) begin
                failures++;
                $display("FAIL glitch_release e=%0d got=%b want=00000", e, rel_a);
            end
            checks++;
            if (lng_a !== ((e == 25) ? 5'b01000 : 5'b00000)) begin
                failures++;
                $display("FAIL glitch_long e=%0d got=%b want=%b", e, lng_a, (e == 25) ? 5'b01000 : 5'b00000);
            end
        end
        raw_a[3] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (rel_a !== ((e == 7) ? 5'b01000 : 5'b00000)) begin
                failures++;
                $display("FAIL glitch_final_release e=%0d got=%b", e, rel_a);
            end
        end
    endtask

    task automatic test_short_press();
        raw_a[4] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 11) raw_a[4] = 1'b0;
            tick();
            checks++;
            if (prs_a !== ((e == 7) ? 5'b10000 : 5'b00000)) begin
                failures++;
                $display("FAIL short_press e=%0d got=%b", e, prs_a);
            end
            checks++;
            if (rel_a !== ((e == 17) ? 5'b10000 : 5'b00000)) begin
                failures++;
                $display("FAIL short_release e=%0d got=%b", e, rel_a);
            end
            checks++;
            if (lvl_a !== ((e >= 7 && e < 17) ? 5'b10000 : 5'b00000)) begin
                failures++;
                $display("FAIL short_level e=%0d got=%b", e, lvl_a);
            end
            checks++;
            if (lng_a !== 5'b00000) begin
                failures++;
                $display("FAIL short_no_long e=%0d got=%b want=00000", e, lng_a);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        raw_a[0] = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        checks++;
        if (lvl_a !== 5'b00001) begin
            failures++;
            $display("FAIL pre_reset_level got=%b want=00001", lvl_a);
        end
        raw_a[2] = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a} !== 20'h0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", {lvl_a, prs_a, rel_a, lng_a});
        end
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if ({lvl_a, prs_a, rel_a, lng_a} !== 20'h0) begin
                failures++;
                $display("FAIL in_reset e=%0d got=%h want=0", e, {lvl_a, prs_a, rel_a, lng_a});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (prs_a !== ((e == 7) ? 5'b00101 : 5'b00000)) begin
                failures++;
                $display("FAIL post_reset_press e=%0d got=%b", e, prs_a);
            end
            checks++;
            if (lvl_a !== ((e >= 7) ? 5'b00101 : 5'b00000)) begin
                failures++;
                $display("FAIL post_reset_level e=%0d got=%b", e, lvl_a);
            end
        end
        raw_a = '0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (rel_a !== ((e == 7) ? 5'b00101 : 5'b00000)) begin
                failures++;
                $display("FAIL post_reset_release e=%0d got=%b", e, rel_a);
            end
        end
    endtask

    task automatic test_polarity_concurrency();
        raw_b[2] = 1'b0;
        raw_b[4] = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            checks++;
            if (prs_b !== ((e == 7) ? 5'b10100 : 5'b00000)) begin
                failures++;
                $display("FAIL lowact_press e=%0d got=%b", e, prs_b);
            end
            checks++;
            if (lvl_b !== ((e >= 7) ? 5'b10100 : 5'b00000)) begin
                failures++;
                $display("FAIL lowact_level e=%0d got=%b", e, lvl_b);
            end
            checks++;
            if (lng_b !== ((e == 23) ? 5'b10100 : 5'b00000)) begin
                failures++;
                $display("FAIL lowact_long e=%0d got=%b", e, lng_b);
            end
            checks++;
            if (prs_a !== 5'b00000) begin
                failures++;
                $display("FAIL lowact_isolation e=%0d got=%b want=00000", e, prs_a);
            end
        end
    endtask

    initial begin
        raw_a = '0;
        raw_b = '1;
        test_reset();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_glitch_while_pressed();
        test_short_press();
        test_reset_mid_debounce();
        test_polarity_concurrency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
